// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: a Moore sequencer over fetch/decode/execute/memory/writeback
// that drives the datapath muxes, write enables and ALU control. It holds no datapath state.
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_J      = 6'b000010;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_next_s;
    logic       wait_last_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic [1:0] aluop_s;

    // Unknown funct codes fall back to add so the datapath never sees an undefined ALU op.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] f);
        logic [2:0] ctl;
        case (aluop)
            2'b00: ctl = 3'b010;
            2'b01: ctl = 3'b110;
            2'b10: begin
                case (f)
                    6'b100000: ctl = 3'b010;
                    6'b100010: ctl = 3'b110;
                    6'b100100: ctl = 3'b000;
                    6'b100101: ctl = 3'b001;
                    6'b101010: ctl = 3'b111;
                    default:   ctl = 3'b010;
                endcase
            end
            default: ctl = 3'b010;
        endcase
        return ctl;
    endfunction

    // State and memory-wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        next_state_s    = FETCH;
        wait_cnt_next_s = 4'd0;
        wait_last_s     = (wait_cnt_r == WAIT_LAST);
        pcwrite_s       = 1'b0;
        branch_s        = 1'b0;
        ir_write_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        illegal_s       = 1'b0;
        iord            = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_src          = 2'b00;
        aluop_s         = 2'b00;
        case (state_r)
            FETCH: begin
                alu_src_b = 2'b01;
                if (wait_last_s) begin
                    ir_write_s   = 1'b1;
                    pcwrite_s    = 1'b1;
                    next_state_s = DECODE;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 4'd1;
                    next_state_s    = FETCH;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = EXEC;
                    OP_BEQ:       next_state_s = BRANCH;
                    OP_ADDI:      next_state_s = ADDIEX;
                    OP_J:         next_state_s = JUMP;
                    default: begin
                        illegal_s    = 1'b1;
                        next_state_s = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_SW) begin
                    next_state_s = MEMWR;
                end else begin
                    next_state_s = MEMRD;
                end
            end
            MEMRD: begin
                iord = 1'b1;
                if (wait_last_s) begin
                    next_state_s = MEMWB;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 4'd1;
                    next_state_s    = MEMRD;
                end
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            EXEC: begin
                alu_src_a    = 1'b1;
                aluop_s      = 2'b10;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                aluop_s   = 2'b01;
                pc_src    = 2'b01;
                branch_s  = 1'b1;
            end
            ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                next_state_s = ADDIWB;
            end
            ADDIWB: begin
                reg_write_s = 1'b1;
            end
            JUMP: begin
                pc_src    = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
        alu_control = alu_decode(aluop_s, funct);
    end

    // Enables are forced low while reset is held so no partial write escapes.
    assign pc_en     = ~rst & (pcwrite_s | (branch_s & zero));
    assign ir_write  = ~rst & ir_write_s;
    assign mem_write = ~rst & mem_write_s;
    assign reg_write = ~rst & reg_write_s;
    assign illegal   = ~rst & illegal_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-level model expands each instruction into its
// expected per-cycle control vectors; one negedge process compares two DUTs (MEM_WAIT 0 and 3).
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal;
    } outv_t;

    typedef struct packed {
        logic       sel;
        logic [7:0] tag;
        logic [7:0] step;
        outv_t      v;
        outv_t      m;
    } ent_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst3 = 1'b1;
    logic [5:0] op0 = 6'd0, funct0 = 6'd0, op3 = 6'd0, funct3 = 6'd0;
    logic zero0 = 1'b0, zero3 = 1'b0;

    logic pc_en0, iord0, mem_write0, ir_write0, reg_dst0, mem_to_reg0, reg_write0, alu_src_a0, illegal0;
    logic [1:0] alu_src_b0, pc_src0;
    logic [2:0] alu_control0;
    logic pc_en3, iord3, mem_write3, ir_write3, reg_dst3, mem_to_reg3, reg_write3, alu_src_a3, illegal3;
    logic [1:0] alu_src_b3, pc_src3;
    logic [2:0] alu_control3;

    outv_t act0, act3;
    ent_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    logic [7:0] cur_tag = 8'd0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .op(op0), .funct(funct0), .zero(zero0),
        .pc_en(pc_en0), .iord(iord0), .mem_write(mem_write0), .ir_write(ir_write0),
        .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .pc_src(pc_src0),
        .alu_control(alu_control0), .illegal(illegal0));

    mips_multicycle_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst3), .op(op3), .funct(funct3), .zero(zero3),
        .pc_en(pc_en3), .iord(iord3), .mem_write(mem_write3), .ir_write(ir_write3),
        .reg_dst(reg_dst3), .mem_to_reg(mem_to_reg3), .reg_write(reg_write3),
        .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3), .pc_src(pc_src3),
        .alu_control(alu_control3), .illegal(illegal3));

    assign act0 = {pc_en0, iord0, mem_write0, ir_write0, reg_dst0, mem_to_reg0, reg_write0,
                   alu_src_a0, alu_src_b0, pc_src0, alu_control0, illegal0};
    assign act3 = {pc_en3, iord3, mem_write3, ir_write3, reg_dst3, mem_to_reg3, reg_write3,
                   alu_src_a3, alu_src_b3, pc_src3, alu_control3, illegal3};

    function automatic outv_t en_mask();
        outv_t m = '0;
        m.pc_en = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    function automatic logic [2:0] model_alu(input logic [5:0] f);
        if (f == 6'b100000) return 3'b010;
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    task automatic push(input logic sel, inout logic [7:0] step, input outv_t v, input outv_t m);
        ent_t e;
        e.sel = sel; e.tag = cur_tag; e.step = step; e.v = v; e.m = m;
        exp_q.push_back(e);
        step = step + 8'd1;
    endtask

    // Expand one instruction into the control vectors of every cycle it occupies.
    task automatic build(input logic sel, input logic [5:0] op, input logic [5:0] f,
                         input logic z, input int w);
        outv_t v, m;
        logic [7:0] s = 8'd0;
        for (int i = 0; i <= w; i++) begin
            v = '0; m = en_mask();
            v.alu_src_b = 2'b01; v.alu_control = 3'b010;
            v.ir_write = (i == w); v.pc_en = (i == w);
            m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.pc_src = 2'b11; m.alu_control = 3'b111;
            push(sel, s, v, m);
        end
        v = '0; m = en_mask();
        v.alu_src_b = 2'b11; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11;
        v.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        push(sel, s, v, m);
        if (op == 6'b100011 || op == 6'b101011) begin
            v = '0; m = en_mask();
            v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_control = 3'b010;
            m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_control = 3'b111;
            push(sel, s, v, m);
            if (op == 6'b100011) begin
                for (int i = 0; i <= w; i++) begin
                    v = '0; m = en_mask(); v.iord = 1'b1; m.iord = 1'b1;
                    push(sel, s, v, m);
                end
                v = '0; m = en_mask();
                v.mem_to_reg = 1'b1; v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
                push(sel, s, v, m);
            end else begin
                v = '0; m = en_mask(); v.iord = 1'b1; v.mem_write = 1'b1; m.iord = 1'b1;
                push(sel, s, v, m);
            end
        end else if (op == 6'b000000) begin
            v = '0; m = en_mask();
            v.alu_src_a = 1'b1; v.alu_control = model_alu(f);
            m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_control = 3'b111;
            push(sel, s, v, m);
            v = '0; m = en_mask();
            v.reg_dst = 1'b1; v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            push(sel, s, v, m);
        end else if (op == 6'b000100) begin
            v = '0; m = en_mask();
            v.alu_src_a = 1'b1; v.alu_control = 3'b110; v.pc_src = 2'b01; v.pc_en = z;
            m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_control = 3'b111; m.pc_src = 2'b11;
            push(sel, s, v, m);
        end else if (op == 6'b001000) begin
            v = '0; m = en_mask();
            v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_control = 3'b010;
            m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_control = 3'b111;
            push(sel, s, v, m);
            v = '0; m = en_mask();
            v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            push(sel, s, v, m);
        end else if (op == 6'b000010) begin
            v = '0; m = en_mask();
            v.pc_src = 2'b10; v.pc_en = 1'b1; m.pc_src = 2'b11;
            push(sel, s, v, m);
        end
    endtask

    // Compare the selected DUT against the head of the expectation queue once per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ent_t e;
            outv_t a;
            e = exp_q.pop_front();
            a = e.sel ? act3 : act0;
            total++;
            if (((a ^ e.v) & e.m) != 16'h0) begin
                bad++;
                $display("FAIL cycle dut%0d instr=%0d step=%0d got=%h want=%h mask=%h",
                         e.sel ? 3 : 0, e.tag, e.step, a, e.v, e.m);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called with the DUT in FETCH just after a rising edge; returns the same way.
    task automatic run_instr(input logic sel, input logic [5:0] op, input logic [5:0] f, input logic z);
        if (sel) begin op3 = op; funct3 = f; zero3 = z; end
        else begin op0 = op; funct0 = f; zero0 = z; end
        cur_tag = cur_tag + 8'd1;
        build(sel, op, f, z, sel ? 3 : 0);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout instr=%0d left=%0d want=0", cur_tag, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    outv_t rst_v, rst_m;

    initial begin
        rst_v = '0; rst_v.alu_src_b = 2'b01; rst_v.alu_control = 3'b010;
        rst_m = en_mask(); rst_m.iord = 1'b1; rst_m.alu_src_a = 1'b1; rst_m.alu_src_b = 2'b11;
        rst_m.pc_src = 2'b11; rst_m.alu_control = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut0", act0 & rst_m, rst_v);
        check("reset_dut3", act3 & rst_m, rst_v);
        rst0 = 1'b0;
        run_instr(1'b0, 6'b100011, 6'b000000, 1'b1);
        run_instr(1'b0, 6'b101011, 6'b000000, 1'b1);
        run_instr(1'b0, 6'b000000, 6'b101010, 1'b0);
        run_instr(1'b0, 6'b000000, 6'b100000, 1'b1);
        run_instr(1'b0, 6'b000000, 6'b100010, 1'b0);
        run_instr(1'b0, 6'b000000, 6'b100100, 1'b0);
        run_instr(1'b0, 6'b000000, 6'b100101, 1'b0);
        run_instr(1'b0, 6'b000000, 6'b000111, 1'b0);
        run_instr(1'b0, 6'b001000, 6'b101010, 1'b1);
        run_instr(1'b0, 6'b000100, 6'b000000, 1'b1);
        run_instr(1'b0, 6'b000100, 6'b000000, 1'b0);
        run_instr(1'b0, 6'b000010, 6'b000000, 1'b1);
        run_instr(1'b0, 6'b111111, 6'b000000, 1'b1);
        // Reset asserted while a store is in its write cycle.
        op0 = 6'b101011; zero0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("memwr_before_rst", {15'd0, mem_write0}, 16'd1);
        rst0 = 1'b1;
        #1;
        check("memwr_during_rst", {15'd0, mem_write0}, 16'd0);
        check("iord_during_rst", {15'd0, iord0}, 16'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        #1;
        check("irwrite_after_rst", {14'd0, ir_write0, pc_en0}, 16'd3);
        run_instr(1'b0, 6'b000000, 6'b101010, 1'b0);
        rst0 = 1'b1;
        rst3 = 1'b0;
        run_instr(1'b1, 6'b101011, 6'b000000, 1'b0);
        run_instr(1'b1, 6'b100011, 6'b000000, 1'b0);
        run_instr(1'b1, 6'b000100, 6'b000000, 1'b1);
        run_instr(1'b1, 6'b111111, 6'b000000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
